// File: rtl/uart_ctrl_p.sv
// Parametrised UART transceiver: configurable framing and baud divisor, filtered
// receiver feeding a first-word-fall-through RX FIFO, optional hardware echo.
module uart_ctrl_p #(
    parameter int unsigned BAUD_DIV   = 1085,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ECHO       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic                          txd,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_cnt
);

    localparam int unsigned BD_W  = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_BITS + 2;

    localparam logic [BD_W-1:0]  BAUD_LAST = BD_W'(BAUD_DIV - 1);
    localparam logic [BD_W-1:0]  BAUD_HALF = BD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit               PAR_EN    = (PARITY != 0);
    localparam bit               PAR_ODD   = (PARITY == 1);
    localparam bit               ECHO_EN   = (ECHO != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Transmit handshake source: external port or FIFO head in echo mode
    logic                 tx_valid_int;
    logic [DATA_BITS-1:0] tx_data_int;
    logic                 tx_fire;
    logic [ENT_W-1:0]     head;
    logic                 rx_valid_q;
    logic                 tx_ready_q;

    assign tx_valid_int = ECHO_EN ? rx_valid_q : tx_valid;
    assign tx_data_int  = ECHO_EN ? head[ENT_W-1:2] : tx_data;
    assign tx_fire      = tx_valid_int & tx_ready_q;

    // ---------------- transmitter ----------------
    state_e               tx_state_q, tx_state_d;
    logic [BD_W-1:0]      tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_ready_d;
    logic                 tx_wrap;

    assign tx_wrap = (tx_baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // txd_d is the line level for the bit that starts on the next cycle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            S_IDLE: begin
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                if (tx_fire) begin
                    tx_state_d = S_START;
                    tx_baud_d  = '0;
                    tx_shift_d = tx_data_int;
                    tx_par_d   = (^tx_data_int) ^ PAR_ODD;
                    txd_d      = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            S_START: begin
                if (tx_wrap) begin
                    tx_state_d = S_DATA;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_baud_d = tx_baud_q + BD_W'(1);
                end
            end
            S_DATA: begin
                if (tx_wrap) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d = '0;
                        if (PAR_EN) begin
                            tx_state_d = S_PARITY;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BD_W'(1);
                end
            end
            S_PARITY: begin
                if (tx_wrap) begin
                    tx_state_d = S_STOP;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b1;
                end else begin
                    tx_baud_d = tx_baud_q + BD_W'(1);
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (tx_wrap) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = S_IDLE;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BD_W'(1);
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_e               rx_state_q, rx_state_d;
    logic [BD_W-1:0]      rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_wrap;
    logic                 push;
    logic [ENT_W-1:0]     push_entry;

    assign rx_wrap = (rx_baud_q == BAUD_LAST);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // Start bit is confirmed at half a bit; all later samples land mid-bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        push       = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_baud_d  = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BD_W'(1);
                end
            end
            S_DATA: begin
                if (rx_wrap) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BD_W'(1);
                end
            end
            S_PARITY: begin
                if (rx_wrap) begin
                    rx_baud_d  = '0;
                    rx_perr_d  = (^rx_shift_q) ^ PAR_ODD ^ rx_s2_q;
                    rx_state_d = S_STOP;
                end else begin
                    rx_baud_d = rx_baud_q + BD_W'(1);
                end
            end
            S_STOP: begin
                if (rx_wrap) begin
                    rx_baud_d  = '0;
                    push       = 1'b1;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_baud_d = rx_baud_q + BD_W'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign push_entry = {rx_shift_q, ~rx_s2_q, rx_perr_q};

    // ---------------- RX FIFO ----------------
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_overrun_q;
    logic             full, pop_req, pop, push_ok;

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop_req = ECHO_EN ? tx_fire : rx_ready;
    assign pop     = pop_req & rx_valid_q;
    assign push_ok = push & (~full | pop);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q        <= cnt_d;
            rx_valid_q   <= (cnt_d != '0);
            rx_overrun_q <= push & full & ~pop;
        end
    end

    assign rx_data       = head[ENT_W-1:2];
    assign rx_frame_err  = head[1];
    assign rx_parity_err = head[0];
    assign rx_valid      = rx_valid_q;
    assign rx_overrun    = rx_overrun_q;
    assign rx_fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_ctrl_p.sv
// Directed bench for uart_ctrl_p: four instances covering 8N1, even/2-stop with a
// small FIFO, odd parity, and echo mode, all at 16 clocks per bit.
module tb_uart_ctrl_p;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      rxd, txd, tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun;
    logic [3:0]      rx_fe, rx_pe;
    logic [3:0][7:0] tx_data, rx_data;
    logic [4:0]      cnt0, cnt2, cnt3;
    logic [2:0]      cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_pulses = 0;

    always #5 clk = ~clk;

    uart_ctrl_p #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(16), .ECHO(0)) u0 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[0]), .txd(txd[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rx_data[0]), .rx_frame_err(rx_fe[0]), .rx_parity_err(rx_pe[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_overrun(rx_overrun[0]),
        .rx_fifo_cnt(cnt0));

    uart_ctrl_p #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4), .ECHO(0)) u1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[1]), .txd(txd[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rx_data[1]), .rx_frame_err(rx_fe[1]), .rx_parity_err(rx_pe[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_overrun(rx_overrun[1]),
        .rx_fifo_cnt(cnt1));

    uart_ctrl_p #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(16), .ECHO(0)) u2 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[2]), .txd(txd[2]),
        .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .rx_data(rx_data[2]), .rx_frame_err(rx_fe[2]), .rx_parity_err(rx_pe[2]),
        .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .rx_overrun(rx_overrun[2]),
        .rx_fifo_cnt(cnt2));

    uart_ctrl_p #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(16), .ECHO(1)) u3 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[3]), .txd(txd[3]),
        .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .rx_data(rx_data[3]), .rx_frame_err(rx_fe[3]), .rx_parity_err(rx_pe[3]),
        .rx_valid(rx_valid[3]), .rx_ready(rx_ready[3]), .rx_overrun(rx_overrun[3]),
        .rx_fifo_cnt(cnt3));

    // Serial frames are LSB-first bit vectors starting with the start bit
    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [11:0] frame;
        int         nbits;
    } tx_vec_t;

    typedef struct {
        int          dut;
        logic [11:0] frame;
        int          nbits;
        logic [7:0]  exp_data;
        logic        exp_fe;
        logic        exp_pe;
    } rx_vec_t;

    tx_vec_t tx_tab [5];
    rx_vec_t rx_tab [5];

    always @(negedge clk) if (rx_overrun[1] === 1'b1) ov_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int idx);
        case (idx)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            2:       return 32'(cnt2);
            default: return 32'(cnt3);
        endcase
    endfunction

    // Independent frame builder for the longer hand-written sequences
    function automatic logic [11:0] mk_frame(input logic [7:0] d, input int par, input int stops);
        logic [11:0] f;
        int          k;
        f = '0;
        f[8:1] = d;
        k = 9;
        if (par != 0) begin
            f[9] = (^d) ^ (par == 1);
            k = 10;
        end
        f[k] = 1'b1;
        if (stops == 2) f[k+1] = 1'b1;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge where tx_ready must be back high
    task automatic tx_frame(input int idx, input logic [7:0] data, input logic [11:0] frame,
                            input int nbits, input string name);
        int bad;
        @(negedge clk);
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        @(negedge clk);
        tx_valid[idx] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                if (txd[idx] !== frame[b] || tx_ready[idx] !== 1'b0) bad++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d_bad_cycles", name, b), 32'(bad), 32'd0);
        end
        check($sformatf("%s_ready_after", name), {31'd0, tx_ready[idx]}, 32'd1);
    endtask

    task automatic rx_send(input int idx, input logic [11:0] frame, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            rxd[idx] = frame[b];
            repeat (16) @(negedge clk);
        end
        rxd[idx] = 1'b1;
    endtask

    task automatic rx_pop_check(input int idx, input logic [7:0] d, input logic fe,
                                input logic pe, input string name);
        check(name, {21'd0, rx_valid[idx], rx_data[idx], rx_fe[idx], rx_pe[idx]},
              {21'd0, 1'b1, d, fe, pe});
        rx_ready[idx] = 1'b1;
        @(negedge clk);
        rx_ready[idx] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] f;
        int          w;
        tx_tab[0] = '{0, 8'hA5, 12'h34A, 10};
        tx_tab[1] = '{1, 8'hA5, 12'hD4A, 12};
        tx_tab[2] = '{2, 8'hA5, 12'h74A, 11};
        tx_tab[3] = '{0, 8'h3C, 12'h278, 10};
        tx_tab[4] = '{1, 8'h07, 12'hE0E, 12};
        rx_tab[0] = '{0, 12'h278, 10, 8'h3C, 1'b0, 1'b0};
        rx_tab[1] = '{0, 12'h0AA, 10, 8'h55, 1'b1, 1'b0};
        rx_tab[2] = '{1, 12'hE1E, 12, 8'h0F, 1'b0, 1'b1};
        rx_tab[3] = '{1, 12'hC1E, 12, 8'h0F, 1'b0, 1'b0};
        rx_tab[4] = '{2, 12'h702, 11, 8'h81, 1'b0, 1'b0};

        rst_n    = 1'b0;
        rxd      = '1;
        tx_valid = '0;
        rx_ready = '0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_u%0d", i),
                  {19'd0, txd[i], tx_ready[i], rx_valid[i], rx_data[i], rx_fe[i], rx_pe[i],
                   rx_overrun[i]},
                  {19'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
            check($sformatf("reset_cnt_u%0d", i), get_cnt(i), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            tx_frame(tx_tab[i].dut, tx_tab[i].data, tx_tab[i].frame, tx_tab[i].nbits,
                     $sformatf("tx%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            rx_send(rx_tab[i].dut, rx_tab[i].frame, rx_tab[i].nbits);
            repeat (4) @(negedge clk);
            rx_pop_check(rx_tab[i].dut, rx_tab[i].exp_data, rx_tab[i].exp_fe,
                         rx_tab[i].exp_pe, $sformatf("rx%0d", i));
            check($sformatf("rx%0d_empty", i), {31'd0, rx_valid[rx_tab[i].dut]}, 32'd0);
        end

        // Back-to-back reception on 8N1
        rx_send(0, 12'h278, 10);
        rx_send(0, 12'h3FE, 10);
        rx_send(0, 12'h200, 10);
        repeat (4) @(negedge clk);
        check("b2b_cnt_peak", get_cnt(0), 32'd3);
        rx_pop_check(0, 8'h3C, 1'b0, 1'b0, "b2b_0");
        rx_pop_check(0, 8'hFF, 1'b0, 1'b0, "b2b_1");
        rx_pop_check(0, 8'h00, 1'b0, 1'b0, "b2b_2");
        check("b2b_cnt_end", get_cnt(0), 32'd0);

        // Pop on an empty FIFO does nothing
        rx_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready[0] = 1'b0;
        check("empty_pop", {30'd0, rx_valid[0], 1'b0} | get_cnt(0), 32'd0);

        // Short low glitch must not start a frame
        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_byte", {31'd0, rx_valid[0]}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO with no pops
        ov_pulses = 0;
        for (int k = 0; k < 5; k++) rx_send(1, mk_frame(8'(8'h11 * (k + 1)), 2, 2), 12);
        repeat (4) @(negedge clk);
        check("ovr_cnt_full", get_cnt(1), 32'd4);
        check("ovr_pulses", 32'(ov_pulses), 32'd1);
        for (int k = 0; k < 4; k++)
            rx_pop_check(1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0, $sformatf("ovr_pop%0d", k));
        check("ovr_cnt_empty", get_cnt(1), 32'd0);

        // Drain/refill rounds walk the pointers around the ring several times
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) rx_send(1, mk_frame(8'(r * 16 + k + 1), 2, 2), 12);
            repeat (4) @(negedge clk);
            for (int k = 0; k < 3; k++)
                rx_pop_check(1, 8'(r * 16 + k + 1), 1'b0, 1'b0, $sformatf("wrap_r%0d_%0d", r, k));
        end
        check("wrap_no_overrun", 32'(ov_pulses), 32'd1);

        // Echo: received byte is retransmitted on txd
        f = 12'h302;
        fork
            rx_send(3, 12'h302, 10);
            begin
                w = 0;
                while (txd[3] !== 1'b0 && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                check("echo_start_seen", {31'd0, (w < 400)}, 32'd1);
                if (w < 400) begin
                    repeat (8) @(negedge clk);
                    for (int b = 0; b < 10; b++) begin
                        check($sformatf("echo_bit%0d", b), {31'd0, txd[3]}, {31'd0, f[b]});
                        repeat (16) @(negedge clk);
                    end
                end
            end
        join
        check("echo_popped", {30'd0, rx_valid[3], tx_ready[3]}, 32'd1);

        // Reset in the middle of a transmit frame
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (38) @(negedge clk);
        check("midtx_low_before_reset", {31'd0, txd[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midtx_txd_async", {31'd0, txd[0]}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midtx_ready_after", {30'd0, tx_ready[0], txd[0]}, 32'd3);
        tx_frame(0, 8'hA5, 12'h34A, 10, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
